// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between the requesting masters and the rr_lock_arbiter.
// The arbiter takes the slave modport; the requester side takes the master modport.
interface rr_lock_arbiter_if #(
    parameter int SEL_WIDTH = 2
);
    localparam int N = 1 << SEL_WIDTH;

    logic [N-1:0]         req;
    logic                 done;
    logic [N-1:0]         gnt;
    logic [SEL_WIDTH-1:0] gnt_id;
    logic                 gnt_valid;
    logic                 timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks its grant until the shared resource pulses done.
// Define ARB_TIMEOUT_EN to force release of a grant held for TIMEOUT cycles.
module rr_lock_arbiter #(
    parameter int SEL_WIDTH = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_lock_arbiter_if.slave   bus
);
    localparam int N = 1 << SEL_WIDTH;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("rr_lock_arbiter: TIMEOUT must be >= 1");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N-1:0]         r_gnt;
    logic [N-1:0]         w_gnt_nxt;
    logic [SEL_WIDTH-1:0] r_gnt_id;
    logic [SEL_WIDTH-1:0] w_gnt_id_nxt;
    logic [SEL_WIDTH-1:0] r_last;
    logic [SEL_WIDTH-1:0] w_last_nxt;
    logic                 w_found;
    logic [SEL_WIDTH-1:0] w_win_id;
    logic [SEL_WIDTH-1:0] w_idx;
    logic                 w_timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;

    assign w_timeout_hit = (r_cnt == CNT_LAST);
    assign bus.timeout   = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign bus.timeout   = 1'b0;
`endif

    assign bus.gnt       = r_gnt;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.gnt_valid = |r_gnt;

    // Scan from the slot after the last winner; the final step (i == N) revisits last itself.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_idx    = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = r_last + SEL_WIDTH'(i);
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_win_id = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_last_nxt   = r_last;
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt  = BUSY;
                    w_gnt_nxt    = N'(1) << w_win_id;
                    w_gnt_id_nxt = w_win_id;
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nxt    = '0;
`endif
                end
            end
            BUSY: begin
                // A real done takes precedence, so a coincident timeout does not pulse.
                if (bus.done || w_timeout_hit) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_gnt_id;
`ifdef ARB_TIMEOUT_EN
                    w_timeout_nxt = !bus.done;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_last   <= '1;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_last   <= w_last_nxt;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench for rr_lock_arbiter: directed scenarios plus random traffic
// against a cycle-level reference model of the round-robin lock rules.
module tb_rr_lock_arbiter;
    localparam int SEL_WIDTH = 2;
    localparam int N         = 1 << SEL_WIDTH;
    localparam int TIMEOUT   = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rr_lock_arbiter_if #(.SEL_WIDTH(SEL_WIDTH)) bus ();

    rr_lock_arbiter #(
        .SEL_WIDTH (SEL_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]         gnt;
        logic [SEL_WIDTH-1:0] id;
        logic                 valid;
        logic                 to;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: who owns the resource, who was served last, how long it has been held.
    int mOwner = -1;
    int mLast  = N - 1;
    int mHeld  = 0;
    bit mTo    = 1'b0;

    function automatic void modelReset();
        mOwner = -1;
        mLast  = N - 1;
        mHeld  = 0;
        mTo    = 1'b0;
    endfunction

    function automatic void modelStep(logic [N-1:0] r, logic d);
        mTo = 1'b0;
        if (mOwner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mLast + k) % N;
                if (r[c]) begin
                    mOwner = c;
                    mHeld  = 1;
                    break;
                end
            end
        end else if (d) begin
            mLast  = mOwner;
            mOwner = -1;
        end else if (TO_EN && mHeld >= TIMEOUT) begin
            mLast  = mOwner;
            mOwner = -1;
            mTo    = 1'b1;
        end else begin
            mHeld++;
        end
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(logic [N-1:0] r, logic d);
        exp_t e;
        @(negedge clk);
        bus.req  = r;
        bus.done = d;
        modelStep(r, d);
        e.gnt   = (mOwner >= 0) ? N'(1) << mOwner : '0;
        e.id    = (mOwner >= 0) ? SEL_WIDTH'(mOwner) : '0;
        e.valid = (mOwner >= 0);
        e.to    = mTo;
        expQ.push_back(e);
    endtask

    // Monitor: one expectation per clock edge that followed a stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("gnt", 32'(bus.gnt), 32'(e.gnt));
                checkOutput("gnt_valid", 32'(bus.gnt_valid), 32'(e.valid));
                checkOutput("timeout", 32'(bus.timeout), 32'(e.to));
                if (e.valid) checkOutput("gnt_id", 32'(bus.gnt_id), 32'(e.id));
            end
        end
    end

    initial begin
        int guard;
        bus.req  = '0;
        bus.done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a grant to requester 2.
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        @(posedge clk);
        #3;
        checkOutput("pre_reset_gnt", 32'(bus.gnt), 32'h4);
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        #1;
        checkOutput("async_reset_gnt", 32'(bus.gnt), 32'h0);
        checkOutput("async_reset_gnt_id", 32'(bus.gnt_id), 32'h0);
        checkOutput("async_reset_gnt_valid", 32'(bus.gnt_valid), 32'h0);
        checkOutput("async_reset_timeout", 32'(bus.timeout), 32'h0);
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Requester 0 has top priority after reset.
        applyStimulus(4'b1111, 1'b0);
        applyStimulus(4'b1111, 1'b1);
        applyStimulus(4'b0000, 1'b0);

        // Single request, done three cycles later.
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b1);
        applyStimulus(4'b0000, 1'b0);

        // Wrap priority: last = 2, requests on 0 and 1 -> 0 wins.
        applyStimulus(4'b0011, 1'b0);
        applyStimulus(4'b0011, 1'b1);
        applyStimulus(4'b0000, 1'b0);

        // Rotation with all requesters active.
        for (int i = 0; i < 24; i++) applyStimulus(4'b1111, (i % 3) == 2);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b0);

        // Lock: requester 1 drops its request while 0 asserts; grant must stay on 1.
        applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0001, 1'b0);
        applyStimulus(4'b0001, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        applyStimulus(4'b0000, 1'b0);
        // done while idle is ignored.
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b0);

        // Grant to 3 with no done: timeout release when enabled, held otherwise.
        for (int i = 0; i < 8; i++) applyStimulus(4'b1000, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(4'b1001, 1'b0);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(0, N * 2 - 1));
            applyStimulus(r, $urandom_range(0, 3) == 0);
        end
        applyStimulus(4'b0000, 1'b0);

        guard = 0;
        while (expQ.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
